// File: rtl/he_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : he_serial_tx
// Purpose  : Hamming SEC encoder with a serial, LSB-position-first frame output.
//            Define HE_SERIAL_TX_SECDED_EN to append an overall parity bit.
// Revision : 1.0  initial release
// ============================================================================
module he_serial_tx #(
    parameter int k   = 11,
    parameter int m   = 4,
    parameter int GAP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [k-1:0] din,
    input  logic         dvld,
    output logic         drdy,
    output logic         sout,
    output logic         sframe,
    output logic         sbusy
);

`ifdef HE_SERIAL_TX_SECDED_EN
    localparam int c_N = k + m + 1;
`else
    localparam int c_N = k + m;
`endif
    localparam int              c_CW      = $clog2(c_N + 1);
    localparam logic [c_CW-1:0] c_LAST    = c_CW'(c_N);
    localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);
    localparam logic [3:0]      c_GAP_LEN = 4'(GAP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [c_N-1:0]  r_shift;
    logic [c_N-1:0]  w_code;
    logic [c_CW-1:0] r_bit_cnt;
    logic [3:0]      r_gap_cnt;
    logic            w_last;
    logic            w_accept;

    // Bit p-1 of the result holds codeword position p.
    function automatic logic [c_N-1:0] encode(input logic [k-1:0] data);
        logic [c_N-1:0] cw;
        logic           par;
        cw = '0;
        for (int p = 1; p <= k + m; p++) begin
            // Data index = p minus one, minus the parity positions at or below p.
            if ((p & (p - 1)) != 0)
                cw[p-1] = data[p - 1 - $clog2(p + 1)];
        end
        for (int i = 0; i < m; i++) begin
            par = 1'b0;
            for (int p = 1; p <= k + m; p++) begin
                if (((p >> i) & 1) != 0)
                    par = par ^ cw[p-1];
            end
            if ((1 << i) <= k + m)
                cw[(1 << i) - 1] = par;
        end
`ifdef HE_SERIAL_TX_SECDED_EN
        cw[c_N-1] = ^cw[k+m-1:0];
`endif
        return cw;
    endfunction

    assign w_code   = encode(din);
    assign w_last   = (r_bit_cnt == c_LAST);
    assign w_accept = drdy & dvld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        drdy   = 1'b0;
        case (r_state)
            S_IDLE: begin
                drdy = 1'b1;
                if (dvld) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_last) begin
                    if (GAP > 0) begin
                        w_next = S_GAP;
                    end else begin
                        // Last bit doubles as an accept slot for gapless streaming.
                        drdy   = 1'b1;
                        w_next = dvld ? S_SHIFT : S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LEN) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        drdy   = drdy & rst;
        sbusy  = (r_state == S_SHIFT);
        sout   = sbusy & r_shift[0];
        sframe = sbusy & (r_bit_cnt == c_ONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_shift   <= w_code;
                r_bit_cnt <= c_ONE;
            end else if (r_state == S_SHIFT) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= w_last ? '0 : r_bit_cnt + c_ONE;
            end

            if (r_state == S_SHIFT && w_last)
                r_gap_cnt <= 4'd1;
            else if (r_state == S_GAP)
                r_gap_cnt <= (r_gap_cnt == c_GAP_LEN) ? 4'd0 : r_gap_cnt + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_he_serial_tx.sv
`default_nettype none
// Bench for he_serial_tx: three instances (gapless, 1-cycle gap, 11-bit with 2-cycle gap)
// checked against a syndrome-based Hamming reference model.
module tb_he_serial_tx;

`ifdef HE_SERIAL_TX_SECDED_EN
    localparam int XB = 1;
`else
    localparam int XB = 0;
`endif
    localparam int N4  = 7 + XB;
    localparam int N11 = 15 + XB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  din0 = '0, din1 = '0;
    logic [10:0] din2 = '0;
    logic        dvld0 = 1'b0, dvld1 = 1'b0, dvld2 = 1'b0;
    logic        drdy0, drdy1, drdy2;
    logic        sout0, sout1, sout2;
    logic        sframe0, sframe1, sframe2;
    logic        sbusy0, sbusy1, sbusy2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    he_serial_tx #(.k(4), .m(3), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .din(din0), .dvld(dvld0), .drdy(drdy0),
        .sout(sout0), .sframe(sframe0), .sbusy(sbusy0));
    he_serial_tx #(.k(4), .m(3), .GAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .dvld(dvld1), .drdy(drdy1),
        .sout(sout1), .sframe(sframe1), .sbusy(sbusy1));
    he_serial_tx #(.k(11), .m(4), .GAP(2)) u_dut2 (
        .clk(clk), .rst(rst), .din(din2), .dvld(dvld2), .drdy(drdy2),
        .sout(sout2), .sframe(sframe2), .sbusy(sbusy2));

    // Parity bits are the syndrome (XOR of indices of set data positions),
    // which forces the whole codeword's syndrome to zero.
    function automatic logic [31:0] model_cw(input logic [31:0] data, input int kk, input int mm);
        logic [31:0] cw;
        int syn;
        int d;
        cw = '0; syn = 0; d = 0;
        for (int p = 1; p <= kk + mm; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (data[d]) begin
                    cw[p-1] = 1'b1;
                    syn = syn ^ p;
                end
                d++;
            end
        end
        for (int i = 0; i < mm; i++) cw[(1 << i) - 1] = syn[i];
`ifdef HE_SERIAL_TX_SECDED_EN
        cw[kk+mm] = ^cw;
`endif
        return cw;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({sout0, sframe0, sbusy0, drdy0} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_dut0 got=%b want=0000", {sout0, sframe0, sbusy0, drdy0});
        end
        n_tests++;
        if ({sout1, sframe1, sbusy1, drdy1} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_dut1 got=%b want=0000", {sout1, sframe1, sbusy1, drdy1});
        end
        n_tests++;
        if ({sout2, sframe2, sbusy2, drdy2} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_dut2 got=%b want=0000", {sout2, sframe2, sbusy2, drdy2});
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({drdy2, drdy1, drdy0} !== 3'b111) begin
            n_fail++; $display("FAIL reset_release_drdy got=%b want=111", {drdy2, drdy1, drdy0});
        end
    endtask

    task automatic test_spec_vectors();
        logic [3:0] w;
        logic [7:0] e_bits;
        for (int v = 0; v < 2; v++) begin
            w      = (v == 0) ? 4'b1011 : 4'hF;
            e_bits = (v == 0) ? 8'h55 : 8'hFF;
            @(negedge clk);
            din1 = w; dvld1 = 1'b1;
            @(posedge clk); @(negedge clk);
            dvld1 = 1'b0; din1 = 4'($urandom);
            for (int p = 1; p <= N4; p++) begin
                n_tests++;
                if ({sout1, sframe1, sbusy1, drdy1} !== {e_bits[p-1], p == 1, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL spec_vec%0d pos%0d got=%b want=%b", v, p,
                             {sout1, sframe1, sbusy1, drdy1}, {e_bits[p-1], p == 1, 1'b1, 1'b0});
                end
                @(negedge clk);
            end
            n_tests++;
            if ({sout1, sframe1, sbusy1, drdy1} !== 4'b0000) begin
                n_fail++; $display("FAIL spec_gap%0d got=%b want=0000", v, {sout1, sframe1, sbusy1, drdy1});
            end
            @(negedge clk);
            n_tests++;
            if ({sbusy1, drdy1} !== 2'b01) begin
                n_fail++; $display("FAIL spec_idle%0d got=%b want=01", v, {sbusy1, drdy1});
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] w;
        logic [31:0] cw, obs, fvec, bvec, mask;
        logic [1:0]  gapv;
        int waitc;
        mask = (32'h1 << N11) - 32'h1;
        for (int f = 0; f < 40; f++) begin
            w  = 11'($urandom);
            cw = model_cw({21'b0, w}, 11, 4);
            @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            waitc = 0;
            while (drdy2 !== 1'b1 && waitc < 20) begin
                @(negedge clk); waitc++;
            end
            n_tests++;
            if (drdy2 !== 1'b1) begin
                n_fail++; $display("FAIL rand_drdy_timeout frame%0d got=%b want=1", f, drdy2);
            end
            din2 = w; dvld2 = 1'b1;
            @(posedge clk); @(negedge clk);
            dvld2 = 1'b0; din2 = 11'($urandom);
            obs = '0; fvec = '0; bvec = '0;
            for (int p = 1; p <= N11; p++) begin
                obs[p-1] = sout2; fvec[p-1] = sframe2; bvec[p-1] = sbusy2;
                @(negedge clk);
            end
            n_tests++;
            if (obs !== cw) begin
                n_fail++; $display("FAIL rand_bits frame%0d din=%h got=%h want=%h", f, w, obs, cw);
            end
            n_tests++;
            if ({fvec, bvec} !== {32'h1, mask}) begin
                n_fail++; $display("FAIL rand_flags frame%0d sframe=%h sbusy=%h want %h %h", f, fvec, bvec, 32'h1, mask);
            end
            gapv = '0;
            for (int g = 0; g < 2; g++) begin
                gapv[g] = sbusy2 | drdy2 | sout2;
                @(negedge clk);
            end
            n_tests++;
            if ({gapv, drdy2} !== 3'b001) begin
                n_fail++; $display("FAIL rand_gap frame%0d got=%b want=001", f, {gapv, drdy2});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ws [6];
        logic [31:0] cw;
        ws[0] = 4'h0; ws[1] = 4'hF;
        for (int j = 2; j < 6; j++) ws[j] = 4'($urandom);
        @(negedge clk);
        din0 = ws[0]; dvld0 = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            cw = model_cw({28'b0, ws[j]}, 4, 3);
            if (j < 5) din0 = ws[j+1];
            else begin dvld0 = 1'b0; din0 = 4'($urandom); end
            for (int p = 1; p <= N4; p++) begin
                n_tests++;
                if ({sout0, sframe0, sbusy0, drdy0} !== {cw[p-1], p == 1, 1'b1, p == N4}) begin
                    n_fail++;
                    $display("FAIL b2b frame%0d pos%0d got=%b want=%b", j, p,
                             {sout0, sframe0, sbusy0, drdy0}, {cw[p-1], p == 1, 1'b1, p == N4});
                end
                @(negedge clk);
            end
        end
        n_tests++;
        if ({sbusy0, drdy0} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_end got=%b want=01", {sbusy0, drdy0});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0]  w;
        logic [31:0] cw;
        @(negedge clk);
        din1 = 4'($urandom); dvld1 = 1'b1;
        @(posedge clk); @(negedge clk);
        dvld1 = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({sout1, sframe1, sbusy1, drdy1} !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_abort got=%b want=0000", {sout1, sframe1, sbusy1, drdy1});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({sbusy1, drdy1} !== 2'b01) begin
            n_fail++; $display("FAIL midrst_release got=%b want=01", {sbusy1, drdy1});
        end
        w = 4'($urandom); cw = model_cw({28'b0, w}, 4, 3);
        din1 = w; dvld1 = 1'b1;
        @(posedge clk); @(negedge clk);
        dvld1 = 1'b0;
        for (int p = 1; p <= N4; p++) begin
            n_tests++;
            if ({sout1, sframe1, sbusy1} !== {cw[p-1], p == 1, 1'b1}) begin
                n_fail++; $display("FAIL midrst_next pos%0d got=%b want=%b", p,
                                   {sout1, sframe1, sbusy1}, {cw[p-1], p == 1, 1'b1});
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore();
        logic [3:0]  w;
        logic [31:0] cw;
        logic [2:0]  idlev;
        @(negedge clk);
        w = 4'($urandom); cw = model_cw({28'b0, w}, 4, 3);
        din1 = w; dvld1 = 1'b1;
        @(posedge clk); @(negedge clk);
        dvld1 = 1'b0;
        for (int p = 1; p <= N4; p++) begin
            n_tests++;
            if ({sout1, sframe1, sbusy1, drdy1} !== {cw[p-1], p == 1, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL ignore pos%0d got=%b want=%b", p,
                                   {sout1, sframe1, sbusy1, drdy1}, {cw[p-1], p == 1, 1'b1, 1'b0});
            end
            dvld1 = 1'($urandom); din1 = 4'($urandom);
            @(negedge clk);
        end
        dvld1 = 1'b0;
        @(negedge clk);
        idlev = '0;
        for (int c = 0; c < 3; c++) begin
            idlev[c] = sbusy1 | ~drdy1;
            @(negedge clk);
        end
        n_tests++;
        if (idlev !== 3'b000) begin
            n_fail++; $display("FAIL ignore_no_extra_frame got=%b want=000", idlev);
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        test_ignore();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
